tristate_bus_transceiver: RTL and testbench
===========================================

Name: tristate_bus_transceiver

Overview:
- Half-duplex endpoint on a shared tristate bus.
- Owns one bus port and is the counterpart of a plain tristate driver.
  - Drives the bus only inside a bounded window, with turnaround cycles on either side.
  - Listens and captures bus data at all other times.
- Sits between a local valid/ready producer/consumer and a multi-drop bus shared with other tristate drivers.

Parameters:
- WIDTH, 8, bus and data width in bits.
- TURN_CYCLES, 1, released-bus turnaround cycles before and after each drive window; legal range 0..15.
- HOLD_CYCLES, 2, cycles the bus is actively driven per transfer; legal range 1..15.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- tx_data  input  WIDTH  word to drive onto the bus.
- tx_valid  input  1  local request to transmit tx_data.
- tx_ready  output  1  high when a new transfer can be accepted.
- rx_strobe  input  1  remote "bus data valid" qualifier; sampled only while listening.
- rx_data  output  WIDTH  last captured bus word.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- bus_oe  output  1  high while this block drives the bus.
- busy  output  1  high whenever state is not IDLE.
- contention  output  1  sticky bus-contention flag (optional feature).
- bus  inout  WIDTH  shared bus; driven with the registered tx word when bus_oe=1, else all-Z.

Behaviour:
- Reset (async assert, sync-to-clk deassert by the user):
  - State IDLE; bus_oe=0 immediately, so the bus goes all-Z without waiting for a clock.
  - tx_ready=1, busy=0, rx_valid=0, rx_data=0, contention=0, internal tx register=0, counter=0.
- FSM states: IDLE, TURN_TX, DRIVE, TURN_RX.
  - tx_ready = (state==IDLE); busy = !tx_ready; bus_oe = (state==DRIVE).
  - All three are decoded from registered state only; no input-to-output combinational paths.
- IDLE:
  - On tx_valid && tx_ready: latch tx_data into the tx register.
  - Next state is TURN_TX with counter=TURN_CYCLES-1, or DRIVE with counter=HOLD_CYCLES-1 if TURN_CYCLES=0.
- TURN_TX: bus released; counts down; at 0, go to DRIVE with counter=HOLD_CYCLES-1.
- DRIVE:
  - bus = tx register, bus_oe=1.
  - At counter 0, go to TURN_RX with counter=TURN_CYCLES-1, or IDLE if TURN_CYCLES=0.
- TURN_RX: bus released; counts down; at 0, go to IDLE.
- Transfer timing: after the accept edge, tx_ready stays low for exactly 2*TURN_CYCLES+HOLD_CYCLES cycles (4 with defaults). bus_oe is high for exactly HOLD_CYCLES consecutive cycles.
- tx_data changes after accept do not affect the driven word.
- tx_valid held high: back-to-back transfers, with a single IDLE cycle between them. That IDLE cycle is where the accept happens.
- Receive:
  - In IDLE with rx_strobe=1: rx_data <= bus and rx_valid=1 on the next cycle, for one cycle.
  - Z/X bus bits are captured as-is.
  - rx_strobe in any other state is ignored: no capture, no pulse, and rx_data holds.
- Simultaneous tx accept and rx_strobe in IDLE: both happen. The capture uses the still-released bus in that cycle.
- Reset asserted mid-DRIVE: bus released asynchronously and no further drive occurs. After deassertion the block is in IDLE and the aborted word is discarded.

Optional Feature:
- Macro: TRISTATE_CONTENTION_CHECK_EN.
- Defined:
  - Every DRIVE cycle compares bus against the tx register using case-inequality, so X/Z from a fighting driver counts as a mismatch.
  - Any mismatch sets contention at the following edge. It stays set until rst_n is asserted.
  - Driving continues normally.
- Undefined: contention is tied to 0 and no compare logic is built.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, bench leaves bus undriven -> bus=8'bzzzzzzzz, bus_oe=0, tx_ready=1, rx_valid=0, rx_data=8'h00.
- Single transmit, defaults: tx_data=8'hA5, tx_valid pulsed 1 cycle -> 1 cycle Z, 2 cycles bus=8'hA5 with bus_oe=1, 1 cycle Z; tx_ready low for exactly 4 cycles.
- Receive: bench drives bus=8'h3C with rx_strobe=1 for 1 IDLE cycle -> next cycle rx_valid=1 and rx_data=8'h3C; rx_strobe during DRIVE -> no rx_valid pulse, rx_data stays 8'h3C.
- Back-to-back with TURN_CYCLES=0, HOLD_CYCLES=1: tx_valid held, tx_data 8'h11 then 8'h22 -> bus shows 8'h11, Z (IDLE), 8'h22; bus_oe never high for 2 consecutive cycles.
- Reset mid-drive: rst_n dropped in the 1st DRIVE cycle of 8'hF0 -> bus Z in the same timestep, then IDLE and tx_ready=1 after release, with no 8'hF0 afterwards.
- Contention (macro defined): bench drives 8'h00 during DRIVE of 8'hFF -> contention=1 next edge and held through later clean transfers until reset. With the macro undefined, contention stays 0.

Source files
------------

// File: rtl/tristate_bus_transceiver.sv
// tristate_bus_transceiver
//   Half-duplex endpoint on a shared multi-drop tristate bus. A word accepted
//   from the local valid/ready side is driven onto the bus for HOLD_CYCLES
//   cycles. The drive window has TURN_CYCLES released-bus turnaround cycles
//   before it and after it. While idle the block listens, and it captures the
//   bus when rx_strobe is high.
//
//   Optional feature: define TRISTATE_CONTENTION_CHECK_EN to build a sticky
//   bus-contention detector. Without the macro, contention is tied to 0.
//
// Parameters
//   WIDTH        bus/data width in bits
//   TURN_CYCLES  released turnaround cycles on each side of a drive window (0..15)
//   HOLD_CYCLES  cycles the bus is actively driven per transfer (1..15)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   tx_data     word to transmit
//   tx_valid    transmit request
//   tx_ready    new transfer can be accepted (IDLE)
//   rx_strobe   remote data-valid qualifier, honoured only in IDLE
//   rx_data     last captured bus word
//   rx_valid    one-cycle pulse, rx_data updated
//   bus_oe      this block is driving the bus
//   busy        not IDLE
//   contention  sticky contention flag (optional feature)
//   bus         shared tristate bus
module tristate_bus_transceiver #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned TURN_CYCLES = 1,
   parameter int unsigned HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             rx_strobe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid,
   output logic             bus_oe,
   output logic             busy,
   output logic             contention,
   inout  wire  [WIDTH-1:0] bus
);

   typedef enum logic [1:0] {
      StIdle,
      StTurnTx,
      StDrive,
      StTurnRx
   } state_e;

   localparam bit       NoTurn   = (TURN_CYCLES == 0);
   localparam logic [3:0] TurnLoad = NoTurn ? 4'd0 : 4'(TURN_CYCLES - 1);
   localparam logic [3:0] HoldLoad = 4'(HOLD_CYCLES - 1);

   state_e             state_q, state_d;
   logic [3:0]         cnt_q, cnt_d;
   logic [WIDTH-1:0]   tx_q, tx_d;
   logic [WIDTH-1:0]   rx_data_q, rx_data_d;
   logic               rx_valid_q, rx_valid_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         cnt_q      <= 4'd0;
         tx_q       <= '0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         tx_q       <= tx_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tx_d    = tx_q;
      unique case (state_q)
         StIdle: begin
            if (tx_valid) begin
               tx_d = tx_data;
               if (NoTurn) begin
                  state_d = StDrive;
                  cnt_d   = HoldLoad;
               end else begin
                  state_d = StTurnTx;
                  cnt_d   = TurnLoad;
               end
            end
         end
         StTurnTx: begin
            if (cnt_q == 4'd0) begin
               state_d = StDrive;
               cnt_d   = HoldLoad;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDrive: begin
            if (cnt_q == 4'd0) begin
               if (NoTurn) begin
                  state_d = StIdle;
                  cnt_d   = 4'd0;
               end else begin
                  state_d = StTurnRx;
                  cnt_d   = TurnLoad;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StTurnRx: begin
            if (cnt_q == 4'd0) begin
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // Capture only while listening; in the accept cycle the bus is still released.
   always_comb begin
      rx_valid_d = (state_q == StIdle) && rx_strobe;
      rx_data_d  = rx_valid_d ? bus : rx_data_q;
   end

   // Outputs come from registered state only, so the async reset releases the bus at once.
   assign tx_ready = (state_q == StIdle);
   assign busy     = !tx_ready;
   assign bus_oe   = (state_q == StDrive);
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign bus      = bus_oe ? tx_q : {WIDTH{1'bz}};

`ifdef TRISTATE_CONTENTION_CHECK_EN
   logic cont_q;

   // Case-inequality so X/Z from a fighting driver counts as a mismatch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cont_q <= 1'b0;
      end else if (bus_oe && (bus !== tx_q)) begin
         cont_q <= 1'b1;
      end
   end

   assign contention = cont_q;
`else
   assign contention = 1'b0;
`endif

endmodule

// File: tb/tb_tristate_bus_transceiver.sv
// Testbench for tristate_bus_transceiver. The reference model tracks each transfer
// as a position on its timeline (1..2*TURN+HOLD) instead of an FSM, and it predicts
// every output each cycle. A second instance with TURN=0, HOLD=1 covers back-to-back.
module tb_tristate_bus_transceiver;

   localparam int TC       = 1;
   localparam int HC       = 2;
   localparam int XFER_LEN = 2 * TC + HC;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       rx_strobe = 1'b0;
   logic       tx_ready, rx_valid, bus_oe, busy, contention;
   logic [7:0] rx_data;
   wire  [7:0] bus;
   logic       tb_en = 1'b0;
   logic [7:0] tb_drv = 8'h00;

   logic [7:0] tx_data2 = 8'h00;
   logic       tx_valid2 = 1'b0;
   logic       tx_ready2, rx_valid2, bus_oe2, busy2, contention2;
   logic [7:0] rx_data2;
   wire  [7:0] bus2;

   int n_cmp = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // Reference model state
   int         m_pos = 0;
   logic [7:0] m_word = 8'h00;
   logic [7:0] m_rx_data = 8'h00;
   logic       m_rx_valid = 1'b0;
   logic       m_rx_known = 1'b1;
   logic       m_cont = 1'b0;

`ifdef TRISTATE_CONTENTION_CHECK_EN
   localparam logic EXP_CONT = 1'b1;
`else
   localparam logic EXP_CONT = 1'b0;
`endif

   assign bus = tb_en ? tb_drv : 8'bzzzzzzzz;

   always #5 clk = ~clk;

   tristate_bus_transceiver #(
      .WIDTH       (8),
      .TURN_CYCLES (TC),
      .HOLD_CYCLES (HC)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .rx_strobe  (rx_strobe),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .bus_oe     (bus_oe),
      .busy       (busy),
      .contention (contention),
      .bus        (bus)
   );

   tristate_bus_transceiver #(
      .WIDTH       (8),
      .TURN_CYCLES (0),
      .HOLD_CYCLES (1)
   ) dut2 (
      .clk        (clk),
      .rst_n      (rst_n),
      .tx_data    (tx_data2),
      .tx_valid   (tx_valid2),
      .tx_ready   (tx_ready2),
      .rx_strobe  (1'b0),
      .rx_data    (rx_data2),
      .rx_valid   (rx_valid2),
      .bus_oe     (bus_oe2),
      .busy       (busy2),
      .contention (contention2),
      .bus        (bus2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_window(input int p);
      return (p >= TC + 1) && (p <= TC + HC);
   endfunction

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   // Reference model: a transfer is a walk through positions 1..XFER_LEN after the accept edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pos      <= 0;
         m_word     <= 8'h00;
         m_rx_data  <= 8'h00;
         m_rx_valid <= 1'b0;
         m_rx_known <= 1'b1;
         m_cont     <= 1'b0;
      end else begin
         m_rx_valid <= (m_pos == 0) && rx_strobe;
         if (m_pos == 0 && rx_strobe) begin
            m_rx_data  <= tb_drv;
            m_rx_known <= tb_en;
         end
         if (m_pos == 0) begin
            if (tx_valid) begin
               m_word <= tx_data;
               m_pos  <= 1;
            end
         end else begin
            m_pos <= (m_pos == XFER_LEN) ? 0 : m_pos + 1;
         end
`ifdef TRISTATE_CONTENTION_CHECK_EN
         if (in_window(m_pos) && tb_en && tb_drv != m_word) m_cont <= 1'b1;
`endif
      end
   end

   // Per-cycle compare against the model
   always @(negedge clk) begin
      if (rst_n && chk_en) begin
         check("tx_ready", {31'd0, tx_ready}, {31'd0, m_pos == 0});
         check("busy", {31'd0, busy}, {31'd0, m_pos != 0});
         check("bus_oe", {31'd0, bus_oe}, {31'd0, in_window(m_pos)});
         check("rx_valid", {31'd0, rx_valid}, {31'd0, m_rx_valid});
         if (m_rx_known) check("rx_data", {24'd0, rx_data}, {24'd0, m_rx_data});
         check("contention", {31'd0, contention}, {31'd0, m_cont});
         if (in_window(m_pos) && !tb_en) check("bus_word", {24'd0, bus}, {24'd0, m_word});
      end
   end

   initial begin
      logic [4:0] oe_seq, rdy_seq;
      int         oe_cnt;
      logic       prev_oe;

      // Reset then idle
      repeat (2) @(posedge clk);
      #2;
      check("rst_bus_oe", {31'd0, bus_oe}, 32'd0);
      check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("rst_rx_data", {24'd0, rx_data}, 32'h00);
      check("rst_contention", {31'd0, contention}, 32'd0);
      rst_n  = 1'b1;
      chk_en = 1'b1;

      // Back-to-back on the TURN=0/HOLD=1 instance
      step();
      tx_valid2 = 1'b1;
      tx_data2  = 8'h11;
      step();
      tx_data2 = 8'h22;
      @(negedge clk);
      check("b2b_oe0", {31'd0, bus_oe2}, 32'd1);
      check("b2b_bus0", {24'd0, bus2}, 32'h11);
      step();
      @(negedge clk);
      check("b2b_oe1", {31'd0, bus_oe2}, 32'd0);
      check("b2b_rdy1", {31'd0, tx_ready2}, 32'd1);
      step();
      tx_valid2 = 1'b0;
      @(negedge clk);
      check("b2b_oe2", {31'd0, bus_oe2}, 32'd1);
      check("b2b_bus2", {24'd0, bus2}, 32'h22);
      step();
      @(negedge clk);
      check("b2b_oe3", {31'd0, bus_oe2}, 32'd0);

      // Single transmit with defaults; tx_data changes after accept
      step();
      tx_valid = 1'b1;
      tx_data  = 8'hA5;
      step();
      tx_valid = 1'b0;
      tx_data  = 8'h5A;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         oe_seq[i]  = bus_oe;
         rdy_seq[i] = tx_ready;
         if (bus_oe) check("tx_word", {24'd0, bus}, 32'hA5);
         step();
      end
      check("tx_oe_seq", {27'd0, oe_seq}, 32'b00110);
      check("tx_rdy_seq", {27'd0, rdy_seq}, 32'b10000);

      // Receive in IDLE, then strobe during DRIVE is ignored
      tb_en     = 1'b1;
      tb_drv    = 8'h3C;
      rx_strobe = 1'b1;
      step();
      tb_en     = 1'b0;
      rx_strobe = 1'b0;
      @(negedge clk);
      check("rx_pulse", {31'd0, rx_valid}, 32'd1);
      check("rx_word", {24'd0, rx_data}, 32'h3C);
      step();
      @(negedge clk);
      check("rx_pulse_end", {31'd0, rx_valid}, 32'd0);
      tx_valid = 1'b1;
      tx_data  = 8'h77;
      step();
      tx_valid = 1'b0;
      step();
      rx_strobe = 1'b1;
      step();
      rx_strobe = 1'b0;
      @(negedge clk);
      check("rx_ign_valid", {31'd0, rx_valid}, 32'd0);
      check("rx_ign_data", {24'd0, rx_data}, 32'h3C);
      repeat (3) step();

      // Reset in the first DRIVE cycle
      tx_valid = 1'b1;
      tx_data  = 8'hF0;
      step();
      tx_valid = 1'b0;
      step();
      check("mid_oe_before", {31'd0, bus_oe}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid_oe_async", {31'd0, bus_oe}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      check("mid_rdy_after", {31'd0, tx_ready}, 32'd1);
      oe_cnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus_oe) oe_cnt++;
         step();
      end
      check("mid_no_redrive", oe_cnt, 32'd0);

      // Contention: bench fights the DUT during DRIVE
      tx_valid = 1'b1;
      tx_data  = 8'hFF;
      step();
      tx_valid = 1'b0;
      step();
      tb_en  = 1'b1;
      tb_drv = 8'h00;
      step();
      tb_en = 1'b0;
      repeat (3) step();
      check("cont_set", {31'd0, contention}, {31'd0, EXP_CONT});
      tx_valid = 1'b1;
      tx_data  = 8'hAA;
      step();
      tx_valid = 1'b0;
      repeat (5) step();
      check("cont_held", {31'd0, contention}, {31'd0, EXP_CONT});
      rst_n = 1'b0;
      step();
      check("cont_cleared", {31'd0, contention}, 32'd0);
      rst_n = 1'b1;
      step();

      // Randomized traffic against the model
      prev_oe = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         step();
         tx_valid  = ($urandom_range(0, 3) != 0);
         tx_data   = 8'($urandom);
         rx_strobe = ($urandom_range(0, 2) == 0);
         if (m_pos == 0 && (rx_strobe || $urandom_range(0, 1) == 1)) begin
            tb_en  = 1'b1;
            tb_drv = 8'($urandom);
         end else begin
            tb_en = 1'b0;
         end
         tx_valid2 = $urandom_range(0, 1) == 1;
         tx_data2  = 8'($urandom);
         @(negedge clk);
         if (prev_oe && bus_oe2) check("b2b_oe_pair", 32'd1, 32'd0);
         prev_oe = bus_oe2;
      end
      step();
      tx_valid  = 1'b0;
      tx_valid2 = 1'b0;
      rx_strobe = 1'b0;
      tb_en     = 1'b0;
      repeat (6) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
